// File: rtl/rst_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module   : rst_seq_pkg
// Purpose  : Shared state encoding and sizing helper for the reset sequencer.
// Revision : 1.0 - initial release
// ============================================================================
package rst_seq_pkg;

   // Encoding is visible on state_o, so the values are fixed.
   typedef enum logic [2:0] {
      IDLE       = 3'd0,
      WAIT_PG    = 3'd1,
      RELEASE    = 3'd2,
      DONE       = 3'd3,
      POWER_DOWN = 3'd4,
      FAULT      = 3'd5
   } seq_state_t;

   // Bits needed to hold 0..n-1, never less than one bit.
   function automatic int cnt_width(input int n);
      return (n < 2) ? 1 : $clog2(n);
   endfunction

endpackage
`default_nettype wire

// File: rtl/rst_seq_tick.sv
`default_nettype none
// ============================================================================
// Module   : rst_seq_tick
// Purpose  : Tick prescaler. Counts 0..TICK_DIV-1 and flags tick while the
//            count sits at its last value; clr restarts the count at zero.
// Revision : 1.0 - initial release
// ============================================================================
module rst_seq_tick
   import rst_seq_pkg::*;
#(
   parameter int TICK_DIV = 1000
) (
   input  logic clk,
   input  logic aaad_rst_n,
   input  logic clr,
   output logic tick
);

   localparam int            CW   = cnt_width(TICK_DIV);
   localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

   logic [CW-1:0] count;

   assign tick = (count == LAST);

   // Free-running divider; a clear or a wrap both restart it at zero.
   always_ff @(posedge clk or negedge aaad_rst_n) begin
      if (!aaad_rst_n) begin
         count <= '0;
      end else if (clr || tick) begin
         count <= '0;
      end else begin
         count <= count + 1'b1;
      end
   end

endmodule
`default_nettype wire

// File: rtl/rst_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : rst_seq_ctrl
// Purpose  : Power-domain reset sequencer. Releases rst_out_n bits in
//            ascending order after power-good is stable, re-asserts them in
//            descending order on disable, and drops all of them at once with
//            a sticky fault flag when power-good is lost.
// Revision : 1.0 - initial release
// ============================================================================
module rst_seq_ctrl
   import rst_seq_pkg::*;
#(
   parameter int NRST         = 4,
   parameter int TICK_DIV     = 1000,
   parameter int GAP_TICKS    = 8,
   parameter int STABLE_TICKS = 16
) (
   input  logic            clk,
   input  logic            aaad_rst_n,
   input  logic            seq_en,
   input  logic            pgood,
   output logic [NRST-1:0] rst_out_n,
   output logic            seq_done,
   output logic            fault,
   output logic [2:0]      state_o
);

   localparam int MAX_TICKS = (GAP_TICKS > STABLE_TICKS) ? GAP_TICKS : STABLE_TICKS;
   localparam int IDX_W     = cnt_width(NRST);
   localparam int SW        = cnt_width(MAX_TICKS);

   localparam logic [IDX_W-1:0] IDX_LAST    = IDX_W'(NRST - 1);
   localparam logic [SW-1:0]    GAP_LAST    = SW'(GAP_TICKS - 1);
   localparam logic [SW-1:0]    STABLE_LAST = SW'(STABLE_TICKS - 1);

   seq_state_t       state;
   seq_state_t       state_nx;
   logic [IDX_W-1:0] idx;
   logic [IDX_W-1:0] idx_nx;
   logic [NRST-1:0]  rst_nx;
   logic             done_nx;
   logic             fault_nx;
   logic [SW-1:0]    step;
   logic             step_evt;
   logic             tick;
   logic             clr;
   logic             gap_done;
   logic             stable_done;

   // Timing restarts from zero on every state change and on every step, so
   // each interval is measured from the edge that began it.
   assign clr         = step_evt || (state_nx != state);
   assign gap_done    = tick && (step == GAP_LAST);
   assign stable_done = tick && (step == STABLE_LAST);
   assign state_o     = state;

   rst_seq_tick #(
      .TICK_DIV (TICK_DIV)
   ) u_tick (
      .clk        (clk),
      .aaad_rst_n (aaad_rst_n),
      .clr        (clr),
      .tick       (tick)
   );

   // Step counter: ticks elapsed since the current interval began.
   always_ff @(posedge clk or negedge aaad_rst_n) begin
      if (!aaad_rst_n) begin
         step <= '0;
      end else if (clr) begin
         step <= '0;
      end else if (tick) begin
         step <= step + 1'b1;
      end
   end

   // Next-state and next-output decode; pgood loss beats seq_en drop beats a step.
   always_comb begin
      state_nx = state;
      idx_nx   = idx;
      rst_nx   = rst_out_n;
      done_nx  = seq_done;
      fault_nx = fault;
      step_evt = 1'b0;

      case (state)
         IDLE: begin
            rst_nx   = '0;
            done_nx  = 1'b0;
            fault_nx = 1'b0;
            if (seq_en && pgood) begin
               state_nx = WAIT_PG;
            end
         end

         WAIT_PG: begin
            if (!pgood || !seq_en) begin
               state_nx = IDLE;
            end else if (stable_done) begin
               state_nx = RELEASE;
               idx_nx   = '0;
            end
         end

         RELEASE: begin
            if (!pgood) begin
               state_nx = FAULT;
               rst_nx   = '0;
               done_nx  = 1'b0;
               fault_nx = 1'b1;
            end else if (!seq_en) begin
               // idx points at the next bit to release, so idx-1 is the top released one.
               if (idx == '0) begin
                  state_nx = IDLE;
               end else begin
                  state_nx = POWER_DOWN;
                  idx_nx   = idx - 1'b1;
               end
            end else if (gap_done) begin
               step_evt    = 1'b1;
               rst_nx[idx] = 1'b1;
               if (idx == IDX_LAST) begin
                  state_nx = DONE;
                  done_nx  = 1'b1;
               end else begin
                  idx_nx = idx + 1'b1;
               end
            end
         end

         DONE: begin
            if (!pgood) begin
               state_nx = FAULT;
               rst_nx   = '0;
               done_nx  = 1'b0;
               fault_nx = 1'b1;
            end else if (!seq_en) begin
               state_nx = POWER_DOWN;
               idx_nx   = IDX_LAST;
               done_nx  = 1'b0;
            end
         end

         POWER_DOWN: begin
            // seq_en is deliberately ignored here: a power-down always completes.
            if (!pgood) begin
               state_nx = FAULT;
               rst_nx   = '0;
               done_nx  = 1'b0;
               fault_nx = 1'b1;
            end else if (gap_done) begin
               step_evt    = 1'b1;
               rst_nx[idx] = 1'b0;
               if (idx == '0) begin
                  state_nx = IDLE;
               end else begin
                  idx_nx = idx - 1'b1;
               end
            end
         end

         FAULT: begin
            rst_nx   = '0;
            done_nx  = 1'b0;
            fault_nx = 1'b1;
            if (!seq_en) begin
               state_nx = IDLE;
               fault_nx = 1'b0;
            end
         end

         default: begin
            state_nx = IDLE;
            rst_nx   = '0;
            done_nx  = 1'b0;
            fault_nx = 1'b0;
         end
      endcase
   end

   // State, index and registered outputs; async reset asserts every domain reset.
   always_ff @(posedge clk or negedge aaad_rst_n) begin
      if (!aaad_rst_n) begin
         state     <= IDLE;
         idx       <= '0;
         rst_out_n <= '0;
         seq_done  <= 1'b0;
         fault     <= 1'b0;
      end else begin
         state     <= state_nx;
         idx       <= idx_nx;
         rst_out_n <= rst_nx;
         seq_done  <= done_nx;
         fault     <= fault_nx;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_rst_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_rst_seq_ctrl
// Purpose  : Directed scoreboard bench for rst_seq_ctrl. Stimulus queues the
//            expected output changes with their cycle; a monitor pops and
//            compares whenever the observed outputs change.
// Revision : 1.0 - initial release
// ============================================================================
module tb_rst_seq_ctrl;

   localparam int NRST = 4;

   localparam logic [2:0] ST_IDLE = 3'd0;
   localparam logic [2:0] ST_WAIT = 3'd1;
   localparam logic [2:0] ST_REL  = 3'd2;
   localparam logic [2:0] ST_DONE = 3'd3;
   localparam logic [2:0] ST_PD   = 3'd4;
   localparam logic [2:0] ST_FLT  = 3'd5;

   logic            clk        = 1'b0;
   logic            aaad_rst_n = 1'b1;
   logic            seq_en     = 1'b0;
   logic            pgood      = 1'b0;
   logic [NRST-1:0] rst_out_n;
   logic            seq_done;
   logic            fault;
   logic [2:0]      state_o;

   typedef struct {
      int         cyc;
      logic [8:0] val;
   } exp_t;

   exp_t q[$];
   int   cyc         = 0;
   int   vectors     = 0;
   int   miscompares = 0;

   rst_seq_ctrl #(
      .NRST         (4),
      .TICK_DIV     (4),
      .GAP_TICKS    (2),
      .STABLE_TICKS (3)
   ) dut (
      .clk        (clk),
      .aaad_rst_n (aaad_rst_n),
      .seq_en     (seq_en),
      .pgood      (pgood),
      .rst_out_n  (rst_out_n),
      .seq_done   (seq_done),
      .fault      (fault),
      .state_o    (state_o)
   );

   always #5 clk = ~clk;

   function automatic logic [8:0] obs();
      return {rst_out_n, seq_done, fault, state_o};
   endfunction

   task automatic expect_at(input int c, input logic [3:0] r, input logic d,
                            input logic f, input logic [2:0] s);
      exp_t e;
      e.cyc = c;
      e.val = {r, d, f, s};
      q.push_back(e);
   endtask

   // Expected changes of a power-up started by inputs driven at cycle n:
   // 12 clk dwell in WAIT_PG, then one release every 8 clk.
   task automatic push_up(input int n, input int releases);
      expect_at(n + 1,  4'b0000, 1'b0, 1'b0, ST_WAIT);
      expect_at(n + 13, 4'b0000, 1'b0, 1'b0, ST_REL);
      if (releases >= 1) expect_at(n + 21, 4'b0001, 1'b0, 1'b0, ST_REL);
      if (releases >= 2) expect_at(n + 29, 4'b0011, 1'b0, 1'b0, ST_REL);
      if (releases >= 3) expect_at(n + 37, 4'b0111, 1'b0, 1'b0, ST_REL);
      if (releases >= 4) expect_at(n + 45, 4'b1111, 1'b1, 1'b0, ST_DONE);
   endtask

   task automatic at_neg(input int c);
      @(negedge clk);
      while (cyc < c) @(negedge clk);
   endtask

   task automatic check(input string name, input logic [8:0] got, input logic [8:0] req);
      vectors++;
      if (got !== req) begin
         miscompares++;
         $display("FAIL %s: got {rst,done,fault,state}=%b required %b", name, got, req);
      end
   endtask

   // Monitor: sample just after each rising edge and score every output change.
   initial begin
      logic [8:0] prev;
      logic [8:0] now;
      exp_t       e;
      prev = 9'b0;
      forever begin
         @(posedge clk);
         cyc++;
         #1;
         while (q.size() > 0 && q[0].cyc < cyc) begin
            e = q.pop_front();
            vectors++;
            miscompares++;
            $display("FAIL missed_change: at cycle %0d got %b required %b", e.cyc, prev, e.val);
         end
         now = obs();
         if (now !== prev) begin
            vectors++;
            if (q.size() == 0) begin
               miscompares++;
               $display("FAIL unexpected_change: cycle %0d got %b required %b", cyc, now, prev);
            end else begin
               e = q.pop_front();
               if (now !== e.val || cyc != e.cyc) begin
                  miscompares++;
                  $display("FAIL step: got %b at cycle %0d required %b at cycle %0d",
                           now, cyc, e.val, e.cyc);
               end
            end
            prev = now;
         end
      end
   end

   // Stimulus.
   initial begin
      int n;
      int m;

      #1 aaad_rst_n = 1'b0;
      repeat (3) @(negedge clk);
      check("reset_state", obs(), 9'b0);
      aaad_rst_n = 1'b1;

      // Nominal power-up.
      at_neg(cyc + 2);
      n = cyc;
      seq_en = 1'b1;
      pgood  = 1'b1;
      push_up(n, 4);
      at_neg(n + 46);
      check("done_held", obs(), {4'b1111, 1'b1, 1'b0, ST_DONE});

      // Nominal power-down; seq_en re-raised mid-way must not abort it.
      at_neg(n + 50);
      m = cyc;
      seq_en = 1'b0;
      expect_at(m + 1,  4'b1111, 1'b0, 1'b0, ST_PD);
      expect_at(m + 9,  4'b0111, 1'b0, 1'b0, ST_PD);
      expect_at(m + 17, 4'b0011, 1'b0, 1'b0, ST_PD);
      expect_at(m + 25, 4'b0001, 1'b0, 1'b0, ST_PD);
      expect_at(m + 33, 4'b0000, 1'b0, 1'b0, ST_IDLE);
      at_neg(m + 12);
      seq_en = 1'b1;
      at_neg(m + 33);
      seq_en = 1'b0;

      // Fault in DONE, held while seq_en stays high.
      at_neg(m + 40);
      n = cyc;
      seq_en = 1'b1;
      push_up(n, 4);
      at_neg(n + 48);
      m = cyc;
      pgood = 1'b0;
      expect_at(m + 1, 4'b0000, 1'b0, 1'b1, ST_FLT);
      at_neg(m + 10);
      check("fault_hold", obs(), {4'b0000, 1'b0, 1'b1, ST_FLT});
      m = cyc;
      seq_en = 1'b0;
      expect_at(m + 1, 4'b0000, 1'b0, 1'b0, ST_IDLE);
      at_neg(m + 3);
      pgood = 1'b1;

      // One-cycle pgood glitch in WAIT_PG, full restart, then abort after 0011.
      at_neg(m + 6);
      n = cyc;
      seq_en = 1'b1;
      expect_at(n + 1, 4'b0000, 1'b0, 1'b0, ST_WAIT);
      at_neg(n + 6);
      pgood = 1'b0;
      expect_at(n + 7, 4'b0000, 1'b0, 1'b0, ST_IDLE);
      at_neg(n + 7);
      pgood = 1'b1;
      push_up(n + 7, 2);
      at_neg(n + 36);
      seq_en = 1'b0;
      expect_at(n + 37, 4'b0011, 1'b0, 1'b0, ST_PD);
      expect_at(n + 45, 4'b0001, 1'b0, 1'b0, ST_PD);
      expect_at(n + 53, 4'b0000, 1'b0, 1'b0, ST_IDLE);

      // seq_en and pgood drop together after 0011: pgood loss wins.
      at_neg(n + 56);
      n = cyc;
      seq_en = 1'b1;
      push_up(n, 2);
      at_neg(n + 29);
      seq_en = 1'b0;
      pgood  = 1'b0;
      expect_at(n + 30, 4'b0000, 1'b0, 1'b1, ST_FLT);
      expect_at(n + 31, 4'b0000, 1'b0, 1'b0, ST_IDLE);
      at_neg(n + 33);
      pgood = 1'b1;

      // Asynchronous reset at 0111.
      at_neg(n + 35);
      n = cyc;
      seq_en = 1'b1;
      push_up(n, 3);
      at_neg(n + 37);
      aaad_rst_n = 1'b0;
      seq_en     = 1'b0;
      expect_at(n + 38, 4'b0000, 1'b0, 1'b0, ST_IDLE);
      #1;
      check("async_reset", obs(), 9'b0);
      at_neg(n + 40);
      aaad_rst_n = 1'b1;
      at_neg(n + 44);
      check("idle_after_reset", obs(), {4'b0000, 1'b0, 1'b0, ST_IDLE});

      // Anything still queued was never produced.
      at_neg(cyc + 4);
      while (q.size() > 0) begin
         vectors++;
         miscompares++;
         $display("FAIL never_seen: required %b at cycle %0d", q[0].val, q[0].cyc);
         void'(q.pop_front());
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   // Global time bound.
   initial begin
      #100000;
      miscompares++;
      $display("FAIL watchdog: got no end of stimulus, required completion within 100000 ns");
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $fatal(1);
   end

endmodule
`default_nettype wire
